// File: rtl/bus_sequencer.sv
// -----------------------------------------------------------------------------
// bus_sequencer
//
// Control sequencer for a single-bus RA/RB/RZ datapath. It accepts a 2-bit
// operation, walks through up to two micro-steps (T1, T2), and drives the
// register load enables and bus driver selects for each step. The accumulate
// operation loops T1/T2 from an internal repeat counter, so the host issues
// a single request for many iterations.
//
// Optional feature macro: BUS_SEQ_STEP_EN
//   When defined, a `step` input is added and T1/T2 hold, with their strobes
//   asserted, until `step` is high at a rising edge. IDLE and DONE ignore it.
//   When undefined there is no `step` port and T states advance every cycle.
//
// Operations (op):
//   00 LDA   : T1 RAin                         -> DONE
//   01 MOVAB : T1 RAout+RBin                   -> DONE
//   10 ADD   : T1 RAout+RZin, T2 RZout+RBin    -> DONE
//   11 ACC   : T1 RBout+RZin, T2 RZout+RBin    -> T1 (cnt != 0, cnt--)
//                                              -> DONE (cnt == 0)
//
// Handshake: `start` is looked at only while the sequencer is IDLE; a high
// `start` at a rising edge in IDLE accepts the request and latches `op` and
// `rpt`. `busy` is high from the cycle after acceptance through DONE, `done`
// is a one-cycle pulse in DONE. A `start` seen in any other state is dropped,
// not queued, so consecutive requests are separated by at least one IDLE.
//
// Ports:
//   clock      in   system clock, rising edge
//   clear      in   asynchronous active-low reset
//   start      in   request strobe
//   op         in   [1:0] operation code
//   rpt        in   [RPT_W-1:0] ACC iteration count minus one
//   step       in   single-step advance (BUS_SEQ_STEP_EN only)
//   busy       out  sequence in progress (T1, T2, DONE)
//   done       out  one-cycle completion pulse
//   RAin/RBin/RZin     out  register load enables
//   RAout/RBout/RZout  out  bus driver selects (at most one high)
//   state_dbg  out  [1:0] current FSM state encoding, for observation
// -----------------------------------------------------------------------------
module bus_sequencer #(
    parameter int RPT_W = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [RPT_W-1:0] rpt,
`ifdef BUS_SEQ_STEP_EN
    input  logic             step,
`endif
    output logic             busy,
    output logic             done,
    output logic             RAin,
    output logic             RBin,
    output logic             RZin,
    output logic             RAout,
    output logic             RBout,
    output logic             RZout,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_LDA   = 2'b00;
    localparam logic [1:0] OP_MOVAB = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_ACC   = 2'b11;

    state_t           state;
    state_t           state_n;
    logic [1:0]       op_q;
    logic [RPT_W-1:0] cnt_q;
    logic             accept;
    logic             cnt_dec;
    logic             advance;

    // Micro-steps advance every cycle unless single-step is built in.
`ifdef BUS_SEQ_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    // State, latched op and repeat counter.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= S_IDLE;
            op_q  <= 2'b00;
            cnt_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_q  <= op;
                cnt_q <= rpt;
            end else if (cnt_dec) begin
                cnt_q <= cnt_q - RPT_W'(1);
            end
        end
    end

    // Next state and strobe decode. Every output below depends only on the
    // registered state, op_q and cnt_q, never on start/op/rpt directly.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        cnt_dec = 1'b0;
        RAin    = 1'b0;
        RBin    = 1'b0;
        RZin    = 1'b0;
        RAout   = 1'b0;
        RBout   = 1'b0;
        RZout   = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = S_T1;
                end
            end

            S_T1: begin
                case (op_q)
                    OP_LDA: begin
                        RAin = 1'b1;
                    end
                    OP_MOVAB: begin
                        RAout = 1'b1;
                        RBin  = 1'b1;
                    end
                    OP_ADD: begin
                        RAout = 1'b1;
                        RZin  = 1'b1;
                    end
                    default: begin // OP_ACC
                        RBout = 1'b1;
                        RZin  = 1'b1;
                    end
                endcase
                if (advance) begin
                    if (op_q == OP_ADD || op_q == OP_ACC) begin
                        state_n = S_T2;
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end

            S_T2: begin
                // Only ADD and ACC reach T2; both copy RZ back into RB.
                RZout = 1'b1;
                RBin  = 1'b1;
                if (advance) begin
                    // Zero test comes before the decrement, so the counter
                    // never wraps and rpt=0 gives exactly one iteration.
                    if (op_q == OP_ACC && cnt_q != '0) begin
                        cnt_dec = 1'b1;
                        state_n = S_T1;
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end

            default: begin // S_DONE
                state_n = S_IDLE;
            end
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_bus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bus_sequencer
//
// Directed bench for bus_sequencer. A small RA/RB/RZ datapath model sits on
// the DUT strobes so operation results (register values) can be compared
// against hand-computed constants. Latency is counted in cycles with the T1
// cycle right after the acceptance edge numbered 1.
// -----------------------------------------------------------------------------
module tb_bus_sequencer;

    localparam int RPT_W = 4;

    logic             clock;
    logic             clear;
    logic             start;
    logic [1:0]       op;
    logic [RPT_W-1:0] rpt;
    logic             step;
    logic             busy;
    logic             done;
    logic             RAin, RBin, RZin, RAout, RBout, RZout;
    logic [1:0]       state_dbg;

    bus_sequencer #(.RPT_W(RPT_W)) dut (
        .clock     (clock),
        .clear     (clear),
        .start     (start),
        .op        (op),
        .rpt       (rpt),
`ifdef BUS_SEQ_STEP_EN
        .step      (step),
`endif
        .busy      (busy),
        .done      (done),
        .RAin      (RAin),
        .RBin      (RBin),
        .RZin      (RZin),
        .RAout     (RAout),
        .RBout     (RBout),
        .RZout     (RZout),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- datapath model ----------------
    logic [31:0] ra, rb, rz, a_val, imm, bus;
    logic [5:0]  strobes;

    assign strobes = {RAin, RBin, RZin, RAout, RBout, RZout};
    assign bus = RAout ? ra : RBout ? rb : RZout ? rz : imm;

    always @(posedge clock) begin
        if (RAin) ra <= bus;
        if (RBin) rb <= bus;
        if (RZin) rz <= a_val + bus;
    end

    // ---------------- bookkeeping ----------------
    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int viol    = 0;
    logic [31:0] exp_q[$];
    logic [5:0]  trace[$];
    logic        busy_at_done;

    // Invariants watched every cycle: one bus driver at most, silent when idle/done.
    always @(negedge clock) begin
        if (clear) begin
            if ($countones({RAout, RBout, RZout}) > 1) viol++;
            if ((!busy || done) && strobes != 6'b0) viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Issue one request, then record strobes each cycle until done (bounded).
    task automatic run_op(input logic [1:0] o, input logic [RPT_W-1:0] r, output int lat);
        @(negedge clock);
        start = 1'b1;
        op    = o;
        rpt   = r;
        @(posedge clock);
        #1 start = 1'b0;
        trace.delete();
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
            trace.push_back(strobes);
        end while (!done && lat < 100);
        busy_at_done = busy;
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        int lat;
        int guard;
        start = 1'b0;
        op    = 2'b00;
        rpt   = '0;
        step  = 1'b1;
        imm   = 32'd0;
        a_val = 32'd0;
        ra = 32'd0; rb = 32'd0; rz = 32'd0;
        clear = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_strobes", {26'b0, strobes}, 32'd0);
        clear = 1'b1;
        @(negedge clock);
        check("rst_state", {30'b0, state_dbg}, 32'd0);

        // LDA 7
        imm = 32'd7;
        exp_q.push_back(32'd2);
        run_op(2'b00, '0, lat);
        check("lda_lat", lat, exp_q.pop_front());
        check("lda_t1", {26'b0, trace[0]}, 32'b100000);
        check("lda_busy_done", {31'b0, busy_at_done}, 32'd1);
        check("lda_ra", ra, 32'd7);

        // MOVAB: RB <- RA, RAout the only driver
        exp_q.push_back(32'd2);
        run_op(2'b01, '0, lat);
        check("movab_lat", lat, exp_q.pop_front());
        check("movab_t1", {26'b0, trace[0]}, 32'b010100);
        check("movab_drv", {29'b0, trace[0][2:0]}, 32'b100);
        check("movab_rb", rb, 32'd7);

        // ADD: A=5, RA=7 -> RB=12
        a_val = 32'd5;
        exp_q.push_back(32'd3);
        run_op(2'b10, '0, lat);
        check("add_lat", lat, exp_q.pop_front());
        check("add_t1", {26'b0, trace[0]}, 32'b001100);
        check("add_t2", {26'b0, trace[1]}, 32'b010001);
        check("add_rb", rb, 32'd12);

        // Clear RB via LDA 0 / MOVAB
        imm = 32'd0;
        run_op(2'b00, '0, lat);
        run_op(2'b01, '0, lat);
        check("prep_rb0", rb, 32'd0);

        // ACC A=3, rpt=4 -> RB=15, 11 cycles
        a_val = 32'd3;
        exp_q.push_back(32'd11);
        run_op(2'b11, 4'd4, lat);
        check("acc4_lat", lat, exp_q.pop_front());
        check("acc4_t1", {26'b0, trace[0]}, 32'b001010);
        check("acc4_t2", {26'b0, trace[1]}, 32'b010001);
        check("acc4_loop", {26'b0, trace[2]}, 32'b001010);
        check("acc4_rb", rb, 32'd15);

        // ACC rpt=0 -> one iteration, RB=18
        exp_q.push_back(32'd3);
        run_op(2'b11, 4'd0, lat);
        check("acc0_lat", lat, exp_q.pop_front());
        check("acc0_rb", rb, 32'd18);

        // ACC rpt=15, A=1 -> 16 iterations, RB=34, 33 cycles
        a_val = 32'd1;
        exp_q.push_back(32'd33);
        run_op(2'b11, 4'd15, lat);
        check("acc15_lat", lat, exp_q.pop_front());
        check("acc15_rb", rb, 32'd34);

        // start while busy ignored; held through DONE, accepted only from IDLE
        @(negedge clock);
        start = 1'b1;
        op    = 2'b11;
        rpt   = 4'd2;
        @(posedge clock);
        #1 start = 1'b0;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
            if (lat == 2) begin start = 1'b1; op = 2'b00; end
            if (lat == 3) start = 1'b0;
            if (lat == 5) start = 1'b1;
        end while (!done && lat < 100);
        check("busy_start_lat", lat, 32'd7);
        check("busy_start_done_busy", {31'b0, busy}, 32'd1);
        @(negedge clock);
        check("busy_start_idle", {30'b0, state_dbg}, 32'd0);
        check("busy_start_idle_busy", {31'b0, busy}, 32'd0);
        @(negedge clock);
        check("busy_start_accept", {30'b0, state_dbg}, 32'd1);
        check("busy_start_lda", {26'b0, strobes}, 32'b100000);
        start = 1'b0;
        guard = 0;
        while (!done && guard < 20) begin @(negedge clock); guard++; end
        check("busy_start_lda_done", {31'b0, done}, 32'd1);
        @(negedge clock);

        // Reset mid-ACC in T2
        @(negedge clock);
        start = 1'b1;
        op    = 2'b11;
        rpt   = 4'd3;
        @(posedge clock);
        #1 start = 1'b0;
        guard = 0;
        do begin @(negedge clock); guard++; end while (state_dbg != 2'd2 && guard < 20);
        check("midrst_in_t2", {30'b0, state_dbg}, 32'd2);
        clear = 1'b0;
        #1;
        check("midrst_strobes", {26'b0, strobes}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        check("midrst_idle", {30'b0, state_dbg}, 32'd0);
        imm = 32'd9;
        exp_q.push_back(32'd2);
        run_op(2'b00, '0, lat);
        check("post_rst_lat", lat, exp_q.pop_front());
        check("post_rst_ra", ra, 32'd9);

`ifdef BUS_SEQ_STEP_EN
        // Single-step ADD: T1 held while step low, one pulse per advance
        step = 1'b0;
        @(negedge clock);
        start = 1'b1;
        op    = 2'b10;
        @(posedge clock);
        #1 start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("step_hold_t1", {26'b0, strobes}, 32'b001100);
        end
        step = 1'b1;
        @(posedge clock);
        #1 step = 1'b0;
        @(negedge clock);
        check("step_t2", {30'b0, state_dbg}, 32'd2);
        check("step_t2_strobes", {26'b0, strobes}, 32'b010001);
        step = 1'b1;
        @(posedge clock);
        #1 step = 1'b0;
        @(negedge clock);
        check("step_done", {31'b0, done}, 32'd1);
        step = 1'b1;
        @(negedge clock);
`endif

        check("invariants", viol, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
